// File: rtl/alu_muldiv_control.sv
// rtl/alu_muldiv_control.sv - ALU control decoder with iterative multiply/divide engine and HI/LO
//
// Decodes ALUOp/funct into the ALU operation select and runs a 1-bit-per-cycle
// multiply/divide engine that owns the HI/LO registers. Stalls the datapath
// whenever a HI/LO-related instruction arrives while the engine is busy.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   ALUOp, funct  operation class from main control and R-type funct field
//   valid_in      qualifies md/mf/mt instructions in decode
//   rs_val/rt_val operand A (multiplicand/dividend/mt source), operand B
//   alu_ctrl      combinational ALU operation select
//   mf_val        HI for mfhi, LO for mflo, else 0
//   stall         hold PC/decode this cycle
//   md_busy       engine not idle
//   md_done       one-cycle pulse when HI/LO are being updated by mult/div
//   div_by_zero   one-cycle pulse with md_done when the divisor was zero

module alu_muldiv_control #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ALUOp,
    input  logic [5:0]        funct,
    input  logic              valid_in,
    input  logic [WIDTH-1:0]  rs_val,
    input  logic [WIDTH-1:0]  rt_val,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [WIDTH-1:0]  mf_val,
    output logic              stall,
    output logic              md_busy,
    output logic              md_done,
    output logic              div_by_zero
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] hi_reg, lo_reg;
    // acc_hi/acc_lo: partial product during MUL, remainder/quotient during DIV
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] opb;
    logic [CNT_W-1:0] cnt;
    logic             sign_a, sign_b, is_div, dz;

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    always_comb begin
        alu_ctrl = CTRL_W'(4'b0000);
        case (ALUOp)
            3'b000: alu_ctrl = CTRL_W'(4'b0010);
            3'b001: alu_ctrl = CTRL_W'(4'b0110);
            3'b100: alu_ctrl = CTRL_W'(4'b0111);
            3'b101: alu_ctrl = CTRL_W'(4'b0001);
            3'b110: alu_ctrl = CTRL_W'(4'b1000);
            3'b010: begin
                case (funct)
                    6'b100000: alu_ctrl = CTRL_W'(4'b0010);
                    6'b100010: alu_ctrl = CTRL_W'(4'b0110);
                    6'b101010: alu_ctrl = CTRL_W'(4'b0111);
                    6'b100101: alu_ctrl = CTRL_W'(4'b0001);
                    default:   alu_ctrl = CTRL_W'(4'b0000);
                endcase
            end
            default: alu_ctrl = CTRL_W'(4'b0000);
        endcase
    end

    // ------------------------------------------------------------------
    // md instruction decode
    // ------------------------------------------------------------------
    logic md_sel;
    logic op_mult, op_multu, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo;
    logic any_md, idle, start_mul, start_div, is_signed, divisor_zero;

    assign md_sel   = valid_in && (ALUOp == 3'b010);
    assign op_mult  = md_sel && (funct == F_MULT);
    assign op_multu = md_sel && (funct == F_MULTU);
    assign op_div   = md_sel && (funct == F_DIV);
    assign op_divu  = md_sel && (funct == F_DIVU);
    assign op_mfhi  = md_sel && (funct == F_MFHI);
    assign op_mflo  = md_sel && (funct == F_MFLO);
    assign op_mthi  = md_sel && (funct == F_MTHI);
    assign op_mtlo  = md_sel && (funct == F_MTLO);
    assign any_md   = op_mult | op_multu | op_div | op_divu |
                      op_mfhi | op_mflo | op_mthi | op_mtlo;

    assign idle         = (state == S_IDLE);
    assign start_mul    = idle && (op_mult | op_multu);
    assign start_div    = idle && (op_div | op_divu);
    assign is_signed    = op_mult | op_div;
    assign divisor_zero = (rt_val == '0);

    // Engine works on magnitudes; signs are reapplied in FIX
    logic [WIDTH-1:0] mag_a, mag_b;
    assign mag_a = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign mag_b = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge, last_iter;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};
    // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow
    assign div_ge    = ~div_diff[WIDTH];
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign prod     = {acc_hi, acc_lo};
    assign prod_neg = -prod;

    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (dz) begin
            fix_hi = acc_hi;
            fix_lo = acc_lo;
        end else if (is_div) begin
            fix_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
            fix_hi = sign_a ? -acc_hi : acc_hi;
        end else if (sign_a ^ sign_b) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_mul) begin
                    state_next = S_MUL;
                end else if (start_div) begin
                    state_next = divisor_zero ? S_FIX : S_DIV;
                end
            end
            S_MUL:   if (last_iter) state_next = S_FIX;
            S_DIV:   if (last_iter) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        md_busy     = (state != S_IDLE);
        md_done     = (state == S_FIX);
        div_by_zero = (state == S_FIX) && dz;
        stall       = any_md && (state != S_IDLE);
    end

    assign mf_val = op_mfhi ? hi_reg : (op_mflo ? lo_reg : '0);

    // ------------------------------------------------------------------
    // Engine and HI/LO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            is_div <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_mul || start_div) begin
                        sign_a <= is_signed && rs_val[WIDTH-1];
                        sign_b <= is_signed && rt_val[WIDTH-1];
                        is_div <= start_div;
                        dz     <= start_div && divisor_zero;
                        cnt    <= '0;
                        if (start_div && divisor_zero) begin
                            acc_hi <= rs_val;
                            acc_lo <= '1;
                            opb    <= '0;
                        end else if (start_mul) begin
                            acc_hi <= '0;
                            acc_lo <= mag_b;
                            opb    <= mag_a;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= mag_a;
                            opb    <= mag_b;
                        end
                    end
                    if (op_mthi) hi_reg <= rs_val;
                    if (op_mtlo) lo_reg <= rs_val;
                end
                S_MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    cnt    <= cnt + 1'b1;
                end
                S_FIX: begin
                    hi_reg <= fix_hi;
                    lo_reg <= fix_lo;
                    cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_control.sv
// tb/tb_alu_muldiv_control.sv - directed self-checking bench for alu_muldiv_control

module tb_alu_muldiv_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ALUOp;
    logic [5:0]  funct;
    logic        valid_in;
    logic [31:0] rs_val, rt_val;
    logic [3:0]  alu_ctrl;
    logic [31:0] mf_val;
    logic        stall, md_busy, md_done, div_by_zero;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    alu_muldiv_control #(.WIDTH(32), .CTRL_W(4), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .ALUOp       (ALUOp),
        .funct       (funct),
        .valid_in    (valid_in),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .alu_ctrl    (alu_ctrl),
        .mf_val      (mf_val),
        .stall       (stall),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic v,
                         input logic [31:0] a, input logic [31:0] b);
        ALUOp    = op;
        funct    = fn;
        valid_in = v;
        rs_val   = a;
        rt_val   = b;
    endtask

    // Issue an md op in IDLE, then count cycles after the accepting edge until md_done
    task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic dz_seen);
        lat     = -1;
        dz_seen = 1'b0;
        drive(3'b010, fn, 1'b1, a, b);
        tick();
        drive(3'b000, 6'd0, 1'b0, 32'd0, 32'd0);
        for (int k = 1; k <= 40; k++) begin
            if (md_done === 1'b1) begin
                lat     = k;
                dz_seen = div_by_zero;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        drive(3'b010, F_MFHI, 1'b1, 32'd0, 32'd0);
        #1 h = mf_val;
        drive(3'b010, F_MFLO, 1'b1, 32'd0, 32'd0);
        #1 l = mf_val;
        drive(3'b000, 6'd0, 1'b0, 32'd0, 32'd0);
    endtask

    logic [2:0]  op_tab   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [3:0]  op_exp   [8] = '{4'b0010, 4'b0110, 4'b0010, 4'b0000, 4'b0111, 4'b0001, 4'b1000, 4'b0000};
    logic [5:0]  fn_tab   [8] = '{6'b100000, 6'b100010, 6'b101010, 6'b100101, 6'b100100, 6'b111111, 6'b011000, 6'b010000};
    logic [3:0]  fn_exp   [8] = '{4'b0010, 4'b0110, 4'b0111, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    initial begin
        int          lat;
        int          n;
        logic        dzs;
        logic [31:0] h, l;

        rst = 1'b1;
        drive(3'b010, F_MFHI, 1'b1, 32'd0, 32'd0);
        #3;
        check("reset_busy", {63'd0, md_busy}, 64'd0);
        check("reset_stall", {63'd0, stall}, 64'd0);
        check("reset_done", {63'd0, md_done}, 64'd0);
        check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        check("reset_mfhi", {32'd0, mf_val}, 64'd0);
        tick();
        rst = 1'b0;
        drive(3'b000, 6'd0, 1'b0, 32'd0, 32'd0);

        // ALU control decode sweep
        for (int i = 0; i < 8; i++) begin
            drive(op_tab[i], 6'b100000, 1'b0, 32'd0, 32'd0);
            #1 check($sformatf("aluop_%0d", i), {60'd0, alu_ctrl}, {60'd0, op_exp[i]});
        end
        for (int i = 0; i < 8; i++) begin
            drive(3'b010, fn_tab[i], 1'b0, 32'd0, 32'd0);
            #1 check($sformatf("funct_%0h", fn_tab[i]), {60'd0, alu_ctrl}, {60'd0, fn_exp[i]});
        end
        drive(3'b000, 6'd0, 1'b0, 32'd0, 32'd0);
        tick();

        // mult -3 * 5
        run_md(F_MULT, 32'hFFFFFFFD, 32'd5, lat, dzs);
        check("mult_latency", 64'(lat), 64'd33);
        check("mult_dbz", {63'd0, dzs}, 64'd0);
        read_hilo(h, l);
        check("mult_hi", {32'd0, h}, 64'hFFFFFFFF);
        check("mult_lo", {32'd0, l}, 64'hFFFFFFF1);

        // multu FFFFFFFF * 2
        run_md(F_MULTU, 32'hFFFFFFFF, 32'd2, lat, dzs);
        check("multu_latency", 64'(lat), 64'd33);
        read_hilo(h, l);
        check("multu_hi", {32'd0, h}, 64'd1);
        check("multu_lo", {32'd0, l}, 64'hFFFFFFFE);

        // divu 100 / 7
        run_md(F_DIVU, 32'd100, 32'd7, lat, dzs);
        check("divu_latency", 64'(lat), 64'd33);
        read_hilo(h, l);
        check("divu_hi", {32'd0, h}, 64'd2);
        check("divu_lo", {32'd0, l}, 64'd14);

        // div -7 / 2
        run_md(F_DIV, 32'hFFFFFFF9, 32'd2, lat, dzs);
        read_hilo(h, l);
        check("div_hi", {32'd0, h}, 64'hFFFFFFFF);
        check("div_lo", {32'd0, l}, 64'hFFFFFFFD);

        // div 5 / 0
        run_md(F_DIV, 32'd5, 32'd0, lat, dzs);
        check("dz_latency", 64'(lat), 64'd1);
        check("dz_flag", {63'd0, dzs}, 64'd1);
        read_hilo(h, l);
        check("dz_hi", {32'd0, h}, 64'd5);
        check("dz_lo", {32'd0, l}, 64'hFFFFFFFF);

        // mthi / mtlo write at next edge
        drive(3'b010, F_MTHI, 1'b1, 32'h0000ABCD, 32'd0);
        tick();
        drive(3'b010, F_MTLO, 1'b1, 32'h00001234, 32'd0);
        tick();
        read_hilo(h, l);
        check("mthi_val", {32'd0, h}, 64'h0000ABCD);
        check("mtlo_val", {32'd0, l}, 64'h00001234);

        // mflo right behind a mult stalls through FIX
        drive(3'b010, F_MULT, 1'b1, 32'hFFFFFFFD, 32'd5);
        tick();
        drive(3'b010, F_MFLO, 1'b1, 32'd0, 32'd0);
        #1;
        check("hazard_busy", {63'd0, md_busy}, 64'd1);
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #2;
        end
        check("hazard_stall_cycles", 64'(n), 64'd33);
        check("hazard_mf_val", {32'd0, mf_val}, 64'hFFFFFFF1);
        check("hazard_busy_end", {63'd0, md_busy}, 64'd0);
        drive(3'b000, 6'd0, 1'b0, 32'd0, 32'd0);
        tick();

        // reset in the middle of a divide
        drive(3'b010, F_DIVU, 1'b1, 32'd100, 32'd7);
        tick();
        drive(3'b010, F_MFLO, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {63'd0, md_busy}, 64'd0);
        check("midrst_stall", {63'd0, stall}, 64'd0);
        check("midrst_lo", {32'd0, mf_val}, 64'd0);
        drive(3'b010, F_MFHI, 1'b1, 32'd0, 32'd0);
        #1 check("midrst_hi", {32'd0, mf_val}, 64'd0);
        tick();
        rst = 1'b0;
        drive(3'b000, 6'd0, 1'b0, 32'd0, 32'd0);
        tick();
        run_md(F_MULT, 32'd7, 32'hFFFFFFFA, lat, dzs);
        check("postrst_latency", 64'(lat), 64'd33);
        read_hilo(h, l);
        check("postrst_hi", {32'd0, h}, 64'hFFFFFFFF);
        check("postrst_lo", {32'd0, l}, 64'hFFFFFFD6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
